// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 2:1 packet arbiter: FSM state encoding,
// source-select constants and the default payload width.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  localparam int DEFAULT_DATA_W = 8;

  // Round-robin priority after a packet from source 'sel' completes:
  // the other source gets first claim next time.
  function automatic logic next_prio(input logic sel);
    next_prio = ~sel;
  endfunction

endpackage

// File: rtl/mux_2_1_bus.sv
// Plain 2:1 bus select. Carries {last,data} of the granted source toward
// the output register.
module mux_2_1_bus #(
  parameter int W = 9
) (
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);

  // Select the granted source bus.
  always_comb begin
    if (sel) begin
      out = in1;
    end else begin
      out = in0;
    end
  end

endmodule

// File: rtl/mux_sel_arbiter_2_1.sv
// Two-source, packet-granular round-robin arbiter feeding one output
// register. A source keeps the grant from its first non-last beat until
// its last beat is accepted; out_sel tells the downstream mux which
// source the held beat came from.
module mux_sel_arbiter_2_1
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sel
);

  arb_state_t      state_r;
  arb_state_t      state_next_s;
  logic            prio_r;
  logic            slot_free_s;
  logic            grant_s;
  logic            grant_sel_s;
  logic            sel_valid_s;
  logic            accept_s;
  logic [DATA_W:0] mux_out_s;
  logic            mux_last_s;
  logic [DATA_W-1:0] mux_data_s;

  assign slot_free_s = ~out_valid | out_ready;
  assign sel_valid_s = grant_sel_s ? in1_valid : in0_valid;
  assign accept_s    = slot_free_s & grant_s & sel_valid_s;
  assign mux_last_s  = mux_out_s[DATA_W];
  assign mux_data_s  = mux_out_s[DATA_W-1:0];

  mux_2_1_bus #(
    .W (DATA_W + 1)
  ) u_bus_mux (
    .sel (grant_sel_s),
    .in0 ({in0_last, in0_data}),
    .in1 ({in1_last, in1_data}),
    .out (mux_out_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state: lock onto a source on a non-last beat, release on its last beat.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !mux_last_s) begin
          state_next_s = (grant_sel_s == SEL_IN1) ? LOCK1 : LOCK0;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOCK0, LOCK1: begin
        if (accept_s && mux_last_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Grant decode: in IDLE pick by valids and priority, in LOCKk only source k.
  always_comb begin
    grant_s     = 1'b0;
    grant_sel_s = SEL_IN0;
    case (state_r)
      IDLE: begin
        if (in0_valid && in1_valid) begin
          grant_s     = 1'b1;
          grant_sel_s = prio_r;
        end else if (in0_valid) begin
          grant_s     = 1'b1;
          grant_sel_s = SEL_IN0;
        end else if (in1_valid) begin
          grant_s     = 1'b1;
          grant_sel_s = SEL_IN1;
        end else begin
          grant_s     = 1'b0;
          grant_sel_s = SEL_IN0;
        end
      end
      LOCK0: begin
        grant_s     = 1'b1;
        grant_sel_s = SEL_IN0;
      end
      LOCK1: begin
        grant_s     = 1'b1;
        grant_sel_s = SEL_IN1;
      end
      default: begin
        grant_s     = 1'b0;
        grant_sel_s = SEL_IN0;
      end
    endcase
  end

  // Readies: granted source only, only when the output slot can take a beat,
  // and forced low while reset is held.
  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    if (!rst && slot_free_s && grant_s) begin
      in0_ready = (grant_sel_s == SEL_IN0);
      in1_ready = (grant_sel_s == SEL_IN1);
    end else begin
      in0_ready = 1'b0;
      in1_ready = 1'b0;
    end
  end

  // Round-robin priority flips away from a source once its packet ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_r <= 1'b0;
    end else if (accept_s && mux_last_s) begin
      prio_r <= next_prio(grant_sel_s);
    end else begin
      prio_r <= prio_r;
    end
  end

  // Output register: load on acceptance, empty when drained with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= SEL_IN0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      out_data  <= mux_data_s;
      out_last  <= mux_last_s;
      out_sel   <= grant_sel_s;
    end else if (slot_free_s) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter_2_1.sv
// Directed bench for mux_sel_arbiter_2_1: reset, round-robin, packet lock,
// backpressure, valid gap and reset mid-packet, with hand-computed values.
module tb_mux_sel_arbiter_2_1;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in0_valid, in1_valid;
  logic              in0_ready, in1_ready;
  logic [DATA_W-1:0] in0_data, in1_data;
  logic              in0_last, in1_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_sel;

  int checks = 0;
  int errors = 0;

  mux_sel_arbiter_2_1 #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic l, input logic s);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, ".data"},  {24'd0, out_data},  {24'd0, d});
    check({tag, ".last"},  {31'd0, out_last},  {31'd0, l});
    check({tag, ".sel"},   {31'd0, out_sel},   {31'd0, s});
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    check({tag, ".rdy0"}, {31'd0, in0_ready}, {31'd0, r0});
    check({tag, ".rdy1"}, {31'd0, in1_ready}, {31'd0, r1});
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 8'h00; in0_last = 1'b1;
    in1_valid = 1'b1; in1_data = 8'h00; in1_last = 1'b1;
    tick();
    tick();
    chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    chk_rdy("reset", 1'b0, 1'b0);

    // Round-robin single-beat packets.
    rst = 1'b0;
    in0_data = 8'hA0; in1_data = 8'hB0;
    #1 chk_rdy("rr0", 1'b1, 1'b0);
    tick();
    chk_out("rr_a0", 1'b1, 8'hA0, 1'b1, 1'b0);
    in0_data = 8'hA1;
    #1 chk_rdy("rr1", 1'b0, 1'b1);
    tick();
    chk_out("rr_b0", 1'b1, 8'hB0, 1'b1, 1'b1);
    in1_data = 8'hB1;
    tick();
    chk_out("rr_a1", 1'b1, 8'hA1, 1'b1, 1'b0);
    in0_valid = 1'b0;
    tick();
    chk_out("rr_b1", 1'b1, 8'hB1, 1'b1, 1'b1);
    in1_valid = 1'b0;
    tick();
    chk_out("rr_idle", 1'b0, 8'hB1, 1'b1, 1'b1);

    // Three-beat packet from in0 locks out in1.
    in0_valid = 1'b1; in0_data = 8'hC0; in0_last = 1'b0;
    in1_valid = 1'b1; in1_data = 8'hD0; in1_last = 1'b1;
    #1 chk_rdy("lk0", 1'b1, 1'b0);
    tick();
    chk_out("lk_c0", 1'b1, 8'hC0, 1'b0, 1'b0);
    in0_data = 8'hC1;
    #1 chk_rdy("lk1", 1'b1, 1'b0);
    tick();
    chk_out("lk_c1", 1'b1, 8'hC1, 1'b0, 1'b0);
    in0_data = 8'hC2; in0_last = 1'b1;
    tick();
    chk_out("lk_c2", 1'b1, 8'hC2, 1'b1, 1'b0);
    in0_valid = 1'b0;
    #1 chk_rdy("lk_rel", 1'b0, 1'b1);
    tick();
    chk_out("lk_d0", 1'b1, 8'hD0, 1'b1, 1'b1);
    in1_valid = 1'b0;

    // Backpressure with 0x5C held.
    in0_valid = 1'b1; in0_data = 8'h5C; in0_last = 1'b1;
    tick();
    chk_out("bp_load", 1'b1, 8'h5C, 1'b1, 1'b0);
    out_ready = 1'b0;
    in0_data = 8'h5D;
    in1_valid = 1'b1; in1_data = 8'h6E; in1_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk_rdy("bp_hold", 1'b0, 1'b0);
      tick();
      chk_out("bp_hold", 1'b1, 8'h5C, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    #1 chk_rdy("bp_rel", 1'b0, 1'b1);
    tick();
    chk_out("bp_6e", 1'b1, 8'h6E, 1'b1, 1'b1);
    in1_valid = 1'b0;
    tick();
    chk_out("bp_5d", 1'b1, 8'h5D, 1'b1, 1'b0);
    in0_valid = 1'b0;
    tick();
    chk_out("bp_empty", 1'b0, 8'h5D, 1'b1, 1'b0);

    // Valid gap inside an in1 packet.
    in1_valid = 1'b1; in1_data = 8'hE0; in1_last = 1'b0;
    in0_valid = 1'b1; in0_data = 8'hF0; in0_last = 1'b1;
    #1 chk_rdy("gap_start", 1'b0, 1'b1);
    tick();
    chk_out("gap_e0", 1'b1, 8'hE0, 1'b0, 1'b1);
    in1_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 check("gap_rdy0", {31'd0, in0_ready}, 32'd0);
      tick();
      chk_out("gap_hold", 1'b0, 8'hE0, 1'b0, 1'b1);
    end
    in1_valid = 1'b1; in1_data = 8'hE1; in1_last = 1'b1;
    #1 chk_rdy("gap_resume", 1'b0, 1'b1);
    tick();
    chk_out("gap_e1", 1'b1, 8'hE1, 1'b1, 1'b1);
    in1_valid = 1'b0;
    #1 chk_rdy("gap_in0", 1'b1, 1'b0);
    tick();
    chk_out("gap_f0", 1'b1, 8'hF0, 1'b1, 1'b0);

    // Reset in the middle of an in0 packet (prio is 1 here).
    in0_data = 8'h11; in0_last = 1'b0;
    tick();
    chk_out("mr_11", 1'b1, 8'h11, 1'b0, 1'b0);
    in0_data = 8'h12; in0_last = 1'b1;
    in1_valid = 1'b1; in1_data = 8'h22; in1_last = 1'b1;
    rst = 1'b1;
    #1 chk_out("mr_rst", 1'b0, 8'h00, 1'b0, 1'b0);
    chk_rdy("mr_rst", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    #1 chk_rdy("mr_post", 1'b1, 1'b0);
    tick();
    chk_out("mr_12", 1'b1, 8'h12, 1'b1, 1'b0);
    in0_valid = 1'b0;
    #1 chk_rdy("mr_next", 1'b0, 1'b1);
    tick();
    chk_out("mr_22", 1'b1, 8'h22, 1'b1, 1'b1);
    in1_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter_2_1.md
MUX_SEL_ARBITER_2_1 -- requirements
Module: mux_sel_arbiter_2_1

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width per source.
REQ-002 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports in0_valid / in1_valid, input, 1, source k offers a beat.
REQ-005 SHALL have ports in0_ready / in1_ready, output, 1, beat of source k accepted when valid&ready.
REQ-006 SHALL have ports in0_data / in1_data, input, DATA_W, source payload.
REQ-007 SHALL have ports in0_last / in1_last, input, 1, final beat of source packet.
REQ-008 SHALL have port out_valid, output, 1, output register holds a beat.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts; transfer when out_valid&out_ready.
REQ-010 SHALL have ports out_data (DATA_W) and out_last (1), output, registered payload/last of selected source.
REQ-011 SHALL have port out_sel, output, 1, registered source index of the beat in the output register (0=in0, 1=in1); doubles as the downstream 2:1 mux select.

Function
REQ-012 SHALL arbitrate between in0 and in1 per packet, round-robin; selected beat is copied into a single output register, latency one cycle from acceptance to out_valid.
REQ-013 SHALL define "slot free" = !out_valid | out_ready; in_k_ready SHALL be 1 only when slot free and source k is granted; never both readies high.
REQ-014 SHALL implement FSM states IDLE, LOCK0, LOCK1.
REQ-015 IDLE: both valid -> grant source equal to prio bit; one valid -> grant it; none -> no grant.
REQ-016 IDLE -> LOCKk on acceptance of a non-last beat from k; acceptance of a last beat from k stays IDLE (single-beat packet).
REQ-017 LOCKk: only source k granted regardless of other valid; LOCKk -> IDLE on acceptance of beat from k with last=1.
REQ-018 prio SHALL become ~k on acceptance of any last beat from k; otherwise hold.
REQ-019 On acceptance: out_valid<=1, out_data<=in_k_data, out_last<=in_k_last, out_sel<=k; slot free with no acceptance: out_valid<=0, data/last/sel hold.
REQ-020 Full throughput: out_ready held 1 with continuous valid SHALL give one beat per cycle.
REQ-021 out_ready=0 while out_valid=1: output register, out_sel and FSM SHALL hold; no input accepted.
REQ-022 Granted source dropping valid mid-packet in LOCKk: no acceptance, FSM holds LOCKk.
REQ-023 Other source raising valid in LOCKk SHALL not be accepted until LOCKk exits.

Reset
REQ-024 rst SHALL asynchronously force: state IDLE, prio 0, out_valid 0, out_data 0, out_last 0, out_sel 0; in0_ready/in1_ready 0 while rst high.
REQ-025 Reset mid-packet SHALL abandon the packet; first cycle after release arbitrates from IDLE with prio 0.

Structure
REQ-026 Shared package mux_arb_pkg SHALL hold state enum (IDLE, LOCK0, LOCK1), SEL_IN0=0, SEL_IN1=1 and default DATA_W.
REQ-027 Data path SHALL use one sub-module mux_2_1_bus (DATA_W+1 wide 2:1 select of {last,data}) driven by the grant bit; FSM/prio/output register in top.

Verification
REQ-028 Reset: assert rst mid-stream -> same cycle out_valid=0, out_sel=0, both readies 0; after release in0/in1 both valid -> in0 granted first.
REQ-029 Round-robin: both sources send single-beat packets 0xA0.., 0xB0.., out_ready=1 -> out_data A0,B0,A1,B1, out_sel 0,1,0,1, one beat/cycle.
REQ-030 Lock: in0 sends 3-beat packet (last on beat 3) while in1 valid -> 3 in0 beats contiguous, then in1 beat, out_sel 0,0,0,1.
REQ-031 Backpressure: out_ready=0 for 4 cycles with out_valid=1, data 0x5C -> out_data stays 0x5C, both readies 0, no beat lost or duplicated after release.
REQ-032 Valid gap: in1 in LOCK1 drops valid 2 cycles while in0 valid -> no in0 acceptance; in1 resumes and completes before in0 granted.
